// File: rtl/ahb_slave_mux_if.sv
// AHB slave-side bus bundle for the slave multiplexer: address-phase selects
// and transfer type from the decoder/master, per-slave responses, and the
// merged response returned to the master.
interface ahb_slave_mux_if;
  // Address-phase selects from the address decoder
  logic        HSEL_1;
  logic        HSEL_2;
  logic        HSEL_3;
  logic        HSEL_DF;
  // Address-phase transfer type
  logic [1:0]  HTRANS;
  // Per-slave data-phase responses
  logic [31:0] HRDATA_1;
  logic [31:0] HRDATA_2;
  logic [31:0] HRDATA_3;
  logic        HREADYOUT_1;
  logic        HREADYOUT_2;
  logic        HREADYOUT_3;
  logic        HRESP_1;
  logic        HRESP_2;
  logic        HRESP_3;
  // Merged response to the master (also HREADY into every slave)
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  // View taken by the multiplexer itself
  modport slave (
    input  HSEL_1, HSEL_2, HSEL_3, HSEL_DF, HTRANS,
    input  HRDATA_1, HRDATA_2, HRDATA_3,
    input  HREADYOUT_1, HREADYOUT_2, HREADYOUT_3,
    input  HRESP_1, HRESP_2, HRESP_3,
    output HRDATA, HREADY, HRESP
  );

  // View taken by the surrounding bus (master, decoder and slaves)
  modport master (
    output HSEL_1, HSEL_2, HSEL_3, HSEL_DF, HTRANS,
    output HRDATA_1, HRDATA_2, HRDATA_3,
    output HREADYOUT_1, HREADYOUT_2, HREADYOUT_3,
    output HRESP_1, HRESP_2, HRESP_3,
    input  HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_slave_mux.sv
// AHB slave response multiplexer with a built-in default slave.
// The data-phase owner is captured from the decoder selects whenever the bus
// is ready, and the response path is steered from that registered owner only,
// so no select or transfer-type input reaches the outputs combinationally.
// The default slave answers active transfers with the two-cycle ERROR
// response and idle/busy transfers with a zero-wait OKAY.
module ahb_slave_mux #(
  parameter logic [31:0] DF_RDATA = 32'h0000_0000
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  ahb_slave_mux_if.slave bus
);

  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_S1   = 3'd1,
    SEL_S2   = 3'd2,
    SEL_S3   = 3'd3,
    SEL_DF   = 3'd4
  } sel_t;

  typedef enum logic [1:0] {
    DF_IDLE = 2'd0,
    DF_ERR1 = 2'd1,
    DF_ERR2 = 2'd2
  } df_state_t;

  sel_t        r_sel_q;
  sel_t        w_sel_next;
  df_state_t   r_df_state;
  logic        r_df_ready;
  logic        r_df_resp;
  logic        w_trans_active;
  logic        w_df_active;
  logic        w_accept;
  logic        w_hready;
  logic        w_hresp;
  logic [31:0] w_hrdata;

  // Resolve simultaneous selects with fixed priority S1 > S2 > S3 > DF
  always_comb begin
    w_sel_next = SEL_NONE;
    if (bus.HSEL_1) begin
      w_sel_next = SEL_S1;
    end else if (bus.HSEL_2) begin
      w_sel_next = SEL_S2;
    end else if (bus.HSEL_3) begin
      w_sel_next = SEL_S3;
    end else if (bus.HSEL_DF) begin
      w_sel_next = SEL_DF;
    end else begin
      w_sel_next = SEL_NONE;
    end
  end

  // NONSEQ and SEQ carry data; IDLE and BUSY only need an OKAY
  assign w_trans_active = (bus.HTRANS == TRANS_NONSEQ) || (bus.HTRANS == TRANS_SEQ);
  // An address phase is taken only when the current data phase completes
  assign w_accept       = w_hready;
  assign w_df_active    = w_accept && (w_sel_next == SEL_DF) && w_trans_active;

  // Data-phase owner: captured on each completed data phase, held on wait states
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sel_q <= SEL_NONE;
    end else if (w_accept) begin
      r_sel_q <= w_sel_next;
    end else begin
      r_sel_q <= r_sel_q;
    end
  end

  // Default slave FSM: two-cycle ERROR response, ready/resp held in registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_df_state <= DF_IDLE;
      r_df_ready <= 1'b1;
      r_df_resp  <= 1'b0;
    end else begin
      case (r_df_state)
        DF_IDLE: begin
          if (w_df_active) begin
            r_df_state <= DF_ERR1;
            r_df_ready <= 1'b0;
            r_df_resp  <= 1'b1;
          end else begin
            r_df_state <= DF_IDLE;
            r_df_ready <= 1'b1;
            r_df_resp  <= 1'b0;
          end
        end
        DF_ERR1: begin
          r_df_state <= DF_ERR2;
          r_df_ready <= 1'b1;
          r_df_resp  <= 1'b1;
        end
        DF_ERR2: begin
          // A new active DF transfer accepted here restarts the ERROR pair
          if (w_df_active) begin
            r_df_state <= DF_ERR1;
            r_df_ready <= 1'b0;
            r_df_resp  <= 1'b1;
          end else begin
            r_df_state <= DF_IDLE;
            r_df_ready <= 1'b1;
            r_df_resp  <= 1'b0;
          end
        end
        default: begin
          r_df_state <= DF_IDLE;
          r_df_ready <= 1'b1;
          r_df_resp  <= 1'b0;
        end
      endcase
    end
  end

  // Steer the response from the registered data-phase owner
  always_comb begin
    w_hready = 1'b1;
    w_hresp  = 1'b0;
    w_hrdata = DF_RDATA;
    case (r_sel_q)
      SEL_S1: begin
        w_hready = bus.HREADYOUT_1;
        w_hresp  = bus.HRESP_1;
        w_hrdata = bus.HRDATA_1;
      end
      SEL_S2: begin
        w_hready = bus.HREADYOUT_2;
        w_hresp  = bus.HRESP_2;
        w_hrdata = bus.HRDATA_2;
      end
      SEL_S3: begin
        w_hready = bus.HREADYOUT_3;
        w_hresp  = bus.HRESP_3;
        w_hrdata = bus.HRDATA_3;
      end
      SEL_DF: begin
        w_hready = r_df_ready;
        w_hresp  = r_df_resp;
        w_hrdata = DF_RDATA;
      end
      SEL_NONE: begin
        w_hready = 1'b1;
        w_hresp  = 1'b0;
        w_hrdata = DF_RDATA;
      end
      default: begin
        w_hready = 1'b1;
        w_hresp  = 1'b0;
        w_hrdata = DF_RDATA;
      end
    endcase
  end

  assign bus.HREADY = w_hready;
  assign bus.HRESP  = w_hresp;
  assign bus.HRDATA = w_hrdata;

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Scoreboard bench for ahb_slave_mux: a driver applies directed and random
// bus cycles, a reference model predicts each cycle's response and queues
// it, and a negedge monitor pops and compares against the DUT.
module tb_ahb_slave_mux;

  localparam logic [31:0] DF_DATA = 32'h0000_0000;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic HCLK;
  logic HRESETn;
  ahb_slave_mux_if bus();

  ahb_slave_mux #(.DF_RDATA(DF_DATA)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_no = 0;

  // stimulus for the next cycle: sel bits {DF,S3,S2,S1}
  logic [3:0]  n_sel   = 4'b0000;
  logic [1:0]  n_trans = 2'b00;
  logic [2:0]  n_rdy   = 3'b111;
  logic [2:0]  n_resp  = 3'b000;
  logic [31:0] n_d [1:3];

  // what the bus carried during the cycle just ending
  logic [3:0]  cur_sel   = 4'b0000;
  logic [1:0]  cur_trans = 2'b00;
  logic        cur_rst   = 1'b0;
  logic        prev_hready = 1'b1;

  // reference model: who owns the data phase, and how far into an ERROR pair
  int          owner   = 0;  // 0 none, 1..3 slaves, 4 default slave
  int          err_cyc = 0;  // 0 none, 1 first ERROR cycle, 2 second

  function automatic int winner(input logic [3:0] sel);
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) return k + 1;
    end
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req, input int cyc);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // one bus cycle: advance model at the edge, drive new inputs, queue expectation
  task automatic step(input logic rst_val);
    exp_t e;
    logic fell;
    @(posedge HCLK);
    if (!cur_rst) begin
      owner   = 0;
      err_cyc = 0;
    end else begin
      if (err_cyc == 1) err_cyc = 2;
      else if (prev_hready && winner(cur_sel) == 4 && cur_trans[1]) err_cyc = 1;
      else err_cyc = 0;
      if (prev_hready) owner = winner(cur_sel);
    end
    #1;
    cyc_no++;
    fell = cur_rst && !rst_val;
    HRESETn         = rst_val;
    bus.HSEL_1      = n_sel[0];
    bus.HSEL_2      = n_sel[1];
    bus.HSEL_3      = n_sel[2];
    bus.HSEL_DF     = n_sel[3];
    bus.HTRANS      = n_trans;
    bus.HREADYOUT_1 = n_rdy[0];
    bus.HREADYOUT_2 = n_rdy[1];
    bus.HREADYOUT_3 = n_rdy[2];
    bus.HRESP_1     = n_resp[0];
    bus.HRESP_2     = n_resp[1];
    bus.HRESP_3     = n_resp[2];
    bus.HRDATA_1    = n_d[1];
    bus.HRDATA_2    = n_d[2];
    bus.HRDATA_3    = n_d[3];
    cur_sel   = n_sel;
    cur_trans = n_trans;
    cur_rst   = rst_val;
    if (!rst_val) begin
      owner   = 0;
      err_cyc = 0;
    end
    e.cyc = cyc_no;
    if (owner >= 1 && owner <= 3) begin
      e.rdy  = n_rdy[owner-1];
      e.resp = n_resp[owner-1];
      e.data = n_d[owner];
    end else if (owner == 4) begin
      e.rdy  = (err_cyc == 1) ? 1'b0 : 1'b1;
      e.resp = (err_cyc != 0) ? 1'b1 : 1'b0;
      e.data = DF_DATA;
    end else begin
      e.rdy  = 1'b1;
      e.resp = 1'b0;
      e.data = DF_DATA;
    end
    prev_hready = e.rdy;
    exp_q.push_back(e);
    if (fell) begin
      #1;
      check("async_rst_hready", {31'd0, bus.HREADY}, 32'd1, cyc_no);
      check("async_rst_hresp",  {31'd0, bus.HRESP},  32'd0, cyc_no);
      check("async_rst_hrdata", bus.HRDATA, DF_DATA, cyc_no);
    end
  endtask

  task automatic set_in(input logic [3:0] sel, input logic [1:0] trans, input logic [2:0] rdy);
    n_sel   = sel;
    n_trans = trans;
    n_rdy   = rdy;
    n_resp  = 3'b000;
  endtask

  // monitor: compare every presented cycle against the oldest expectation
  always @(negedge HCLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("hready", {31'd0, bus.HREADY}, {31'd0, e.rdy},  e.cyc);
      check("hresp",  {31'd0, bus.HRESP},  {31'd0, e.resp}, e.cyc);
      check("hrdata", bus.HRDATA, e.data, e.cyc);
    end
  end

  initial begin
    HRESETn = 1'b0;
    n_d[1] = 32'hFFFF_FFFF;
    n_d[2] = 32'h1234_5678;
    n_d[3] = 32'hA5A5_0003;
    bus.HSEL_1 = 1'b0; bus.HSEL_2 = 1'b0; bus.HSEL_3 = 1'b0; bus.HSEL_DF = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HREADYOUT_1 = 1'b1; bus.HREADYOUT_2 = 1'b1; bus.HREADYOUT_3 = 1'b1;
    bus.HRESP_1 = 1'b0; bus.HRESP_2 = 1'b0; bus.HRESP_3 = 1'b0;
    bus.HRDATA_1 = 32'h0; bus.HRDATA_2 = 32'h0; bus.HRDATA_3 = 32'h0;

    // reset held, nothing selected
    set_in(4'b0000, 2'b00, 3'b111);
    for (int i = 0; i < 4; i++) step(1'b0);
    for (int i = 0; i < 2; i++) step(1'b1);

    // S2 NONSEQ, one wait state, then data while S1 shows all-ones
    set_in(4'b0010, 2'b10, 3'b111); step(1'b1);
    set_in(4'b0000, 2'b00, 3'b101); step(1'b1);
    set_in(4'b0000, 2'b00, 3'b111); step(1'b1);
    step(1'b1);

    // DF NONSEQ: ERROR pair then OKAY
    set_in(4'b1000, 2'b10, 3'b111); step(1'b1);
    set_in(4'b0000, 2'b00, 3'b111);
    for (int i = 0; i < 3; i++) step(1'b1);

    // DF IDLE and DF BUSY: zero-wait OKAY
    set_in(4'b1000, 2'b00, 3'b111); step(1'b1);
    set_in(4'b1000, 2'b01, 3'b111); step(1'b1);
    set_in(4'b0000, 2'b00, 3'b111); step(1'b1);
    step(1'b1);

    // S3 stalls three cycles while S1 waits in the address phase
    set_in(4'b0100, 2'b10, 3'b111); step(1'b1);
    set_in(4'b0001, 2'b10, 3'b011);
    for (int i = 0; i < 3; i++) step(1'b1);
    set_in(4'b0001, 2'b10, 3'b111); step(1'b1);
    set_in(4'b0000, 2'b00, 3'b111); step(1'b1);
    step(1'b1);

    // back-to-back DF NONSEQ: ERR2 goes straight to ERR1
    set_in(4'b1000, 2'b10, 3'b111);
    for (int i = 0; i < 3; i++) step(1'b1);
    set_in(4'b0000, 2'b00, 3'b111);
    for (int i = 0; i < 3; i++) step(1'b1);

    // reset pulse during ERR1, then S1 NONSEQ completes normally
    set_in(4'b1000, 2'b10, 3'b111); step(1'b1);
    set_in(4'b0000, 2'b00, 3'b111); step(1'b0);
    set_in(4'b0001, 2'b10, 3'b111); step(1'b1);
    set_in(4'b0000, 2'b00, 3'b111); step(1'b1);
    step(1'b1);

    // randomized traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      n_sel   = 4'($urandom_range(0, 15));
      n_trans = 2'($urandom_range(0, 3));
      for (int k = 0; k < 3; k++) n_rdy[k] = ($urandom_range(0, 3) != 0);
      n_resp  = 3'($urandom_range(0, 7));
      n_d[1]  = $urandom;
      n_d[2]  = $urandom;
      n_d[3]  = $urandom;
      step(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
    end

    @(negedge HCLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mux.md
AHB_SLAVE_MUX -- requirements
Module: ahb_slave_mux

Interface
REQ-001 Parameter: DF_RDATA, default 32'h0000_0000, read data driven while the data phase is owned by the internal default slave or by no slave.
REQ-002 HCLK  input  1  bus clock; all state changes on rising edge.
REQ-003 HRESETn  input  1  reset, asynchronous, active-low.
REQ-004 HSEL_1, HSEL_2, HSEL_3, HSEL_DF  input  1 each  address-phase slave selects from the address decoder.
REQ-005 HTRANS  input  2  address-phase transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-006 HRDATA_1, HRDATA_2, HRDATA_3  input  32 each  slave read data.
REQ-007 HREADYOUT_1, HREADYOUT_2, HREADYOUT_3  input  1 each  slave ready.
REQ-008 HRESP_1, HRESP_2, HRESP_3  input  1 each  slave response: 0=OKAY, 1=ERROR.
REQ-009 HRDATA  output  32  read data to the master.
REQ-010 HREADY  output  1  transfer ready to the master; also the HREADY input to all slaves.
REQ-011 HRESP  output  1  response to the master.

Function
REQ-012 The block SHALL hold a data-phase owner register sel_q with values NONE, S1, S2, S3 or DF.
REQ-013 sel_q SHALL load from the HSEL_* inputs only on a rising HCLK edge where HREADY=1; while HREADY=0, sel_q and all address-phase sampling SHALL hold.
REQ-014 If more than one HSEL is high, the load SHALL use priority HSEL_1 > HSEL_2 > HSEL_3 > HSEL_DF; if none is high, sel_q SHALL load NONE.
REQ-015 The outputs SHALL be selected as follows:
- sel_q=Sn: HRDATA=HRDATA_n, HREADY=HREADYOUT_n, HRESP=HRESP_n.
- sel_q=DF: default-slave values (REQ-016 to REQ-019), HRDATA=DF_RDATA.
- sel_q=NONE: HREADY=1, HRESP=0, HRDATA=DF_RDATA.
REQ-016 The default slave SHALL run an FSM with states IDLE, ERR1 and ERR2.
REQ-017 In IDLE, an accepted address phase (HREADY=1) with HSEL_DF winning priority and HTRANS[1]=1 SHALL move the FSM to ERR1; all other cases SHALL stay in IDLE.
REQ-018 In ERR1 the default slave SHALL drive ready=0 and resp=1; the next state SHALL be ERR2.
REQ-019 In ERR2 the default slave SHALL drive ready=1 and resp=1; the next state SHALL be ERR1 if an active DF transfer (REQ-017 condition) is accepted in the same cycle, otherwise IDLE.
REQ-020 A DF-selected IDLE or BUSY transfer SHALL complete with zero wait states and OKAY (ready=1, resp=0).
REQ-021 No combinational path SHALL exist from HSEL_* or HTRANS to HRDATA, HREADY or HRESP; those outputs SHALL depend only on sel_q, FSM state and slave inputs.
REQ-022 Latency SHALL be exactly one data phase: the response for an address phase accepted at edge N SHALL appear in the cycle following edge N.
REQ-023 Back-to-back pipelined transfers to different slaves SHALL switch the mux on the edge where the previous data phase completes (HREADY=1), with no idle cycle inserted.

Reset
REQ-024 On HRESETn=0, sel_q SHALL become NONE and the FSM SHALL become IDLE immediately, without waiting for an HCLK edge.
REQ-025 While in reset, outputs SHALL be HREADY=1, HRESP=0 and HRDATA=DF_RDATA.
REQ-026 Assertion of reset mid-transfer, including in ERR1 or ERR2, SHALL abort the transfer with no residual state.
REQ-027 The first address phase after HRESETn deasserts SHALL be accepted on the first rising HCLK edge.

Verification
REQ-028 Reset, all HSEL=0, several clocks -> HREADY=1, HRESP=0, HRDATA=32'h0 every cycle.
REQ-029 HSEL_2=1 with HTRANS=NONSEQ, then HRDATA_2=32'h1234_5678 with HREADYOUT_2=0 for 1 cycle then 1, while HRDATA_1=32'hFFFF_FFFF -> HREADY 0 then 1, HRDATA=32'h1234_5678, HRESP=0.
REQ-030 HSEL_DF=1 with HTRANS=NONSEQ -> cycle+1: HREADY=0, HRESP=1; cycle+2: HREADY=1, HRESP=1; cycle+3 with no further DF transfer: HREADY=1, HRESP=0.
REQ-031 HSEL_DF=1 with HTRANS=IDLE -> next cycle HREADY=1, HRESP=0; FSM stays IDLE.
REQ-032 Data phase on S3 with HREADYOUT_3=0 for 3 cycles while HSEL_1=1 is presented -> HRDATA tracks HRDATA_3 until HREADYOUT_3=1, then switches to HRDATA_1 on the following cycle; also two consecutive NONSEQ to DF -> ERROR pairs with ERR2 going directly to ERR1.
REQ-033 HRESETn pulsed low during ERR1 -> HREADY=1 and HRESP=0 asynchronously; after release, a NONSEQ to S1 completes normally.
